// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave; a control byte selects a channel, then DW-bit words are read from rd_data or written to wr_data
module spi_reg_bank #(
    parameter int         N_CH = 4,
    parameter int         DW   = 32,
    parameter logic [7:0] ID   = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sck,
    input  logic               ncs,
    input  logic               mosi,
    output logic               miso,
    input  logic [N_CH*DW-1:0] rd_data,
    output logic [N_CH*DW-1:0] wr_data,
    output logic [N_CH-1:0]    wr_strobe,
    output logic [7:0]         ctrl_q,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;
    state_t                  state_q, state_d;
    logic [1:0]              arst_q;
    logic                    arst;
    logic [2:0]              sck_q, ncs_q;
    logic [1:0]              mosi_q;
    logic                    sck_rise, sck_fall, ncs_rise, ncs_fall;
    logic [5:0]              cnt_q, cnt_d, ch_q, ch_d, ch_nx;
    logic [DW-1:0]           word_q, word_d, tx_q, tx_d;
    logic [7:0]              ctrl_d;
    logic [N_CH-1:0][DW-1:0] wr_q, wr_d;
    logic [N_CH-1:0]         stb_d;
    logic [63:0][DW-1:0]     rd_w;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) arst_q <= 2'b11;
        else     arst_q <= {arst_q[0], 1'b0};
    end
    assign arst = arst_q[1];
    // Synchronisers carry no reset so a chip select held low across reset does not fake a fresh fall
    always_ff @(posedge clk) begin
        sck_q  <= {sck_q[1:0], sck};
        ncs_q  <= {ncs_q[1:0], ncs};
        mosi_q <= {mosi_q[0], mosi};
    end
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ncs_rise = ncs_q[1] & ~ncs_q[2];
    assign ncs_fall = ~ncs_q[1] & ncs_q[2];
    // Channels beyond N_CH read as zero through the zero-extended view
    assign rd_w = (64*DW)'(rd_data);
    assign ch_nx = ctrl_q[6] ? ((7'(ch_q) + 7'd1 == 7'(N_CH)) ? 6'd0 : ch_q + 6'd1) : ch_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        word_d  = word_q;
        tx_d    = tx_q;
        ctrl_d  = ctrl_q;
        wr_d    = wr_q;
        stb_d   = '0;
        if (state_q == IDLE) begin
            if (ncs_fall) begin
                state_d = CTRL;
                cnt_d   = '0;
                tx_d    = DW'(ID) << (DW - 8);
            end
        end else begin
            if (sck_rise) begin
                word_d = {word_q[DW-2:0], mosi_q[1]};
                cnt_d  = cnt_q + 6'd1;
                if (state_q == CTRL && cnt_q == 6'd7) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    ctrl_d  = word_d[7:0];
                    ch_d    = word_d[5:0];
                    tx_d    = word_d[7] ? '0 : rd_w[word_d[5:0]];
                end else if (state_q == DATA && cnt_q == 6'(DW - 1)) begin
                    cnt_d = '0;
                    ch_d  = ch_nx;
                    tx_d  = ctrl_q[7] ? '0 : rd_w[ch_nx];
                    for (int k = 0; k < N_CH; k++)
                        if (ctrl_q[7] && ch_q == 6'(k)) begin
                            wr_d[k]  = word_d;
                            stb_d[k] = 1'b1;
                        end
                end
            // The fall right after a word load keeps the freshly loaded MSB on miso
            end else if (sck_fall && (state_q == CTRL || cnt_q != '0)) begin
                tx_d = tx_q << 1;
            end
            if (ncs_rise) state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            word_q    <= '0;
            tx_q      <= '0;
            ctrl_q    <= '0;
            wr_q      <= '0;
            wr_strobe <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            word_q    <= word_d;
            tx_q      <= tx_d;
            ctrl_q    <= ctrl_d;
            wr_q      <= wr_d;
            wr_strobe <= stb_d;
        end
    end
    assign wr_data = wr_q;
    assign busy    = state_q != IDLE;
    assign miso    = (state_q != IDLE) && tx_q[DW-1];
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: bit-banged SPI master with queued miso bits and queued expected register writes
module tb_spi_reg_bank;
    localparam int N_CH = 4;
    localparam int DW   = 32;
    logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ncs = 1'b1, mosi = 1'b0;
    logic               miso;
    logic [N_CH*DW-1:0] rd_data = '0;
    logic [N_CH*DW-1:0] wr_data;
    logic [N_CH-1:0]    wr_strobe;
    logic [7:0]         ctrl_q;
    logic               busy;
    int vectors = 0, errors = 0, cyc = 0, rise_cyc = 0;
    typedef struct {int ch; logic [DW-1:0] data;} wr_t;
    wr_t           wq[$];
    logic          mq[$];
    logic [DW-1:0] model[N_CH];
    wr_t           mon_e;
    logic [N_CH-1:0] mon_stb;

    spi_reg_bank #(.N_CH(N_CH), .DW(DW), .ID(8'hA5)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ncs(ncs), .mosi(mosi), .miso(miso),
        .rd_data(rd_data), .wr_data(wr_data), .wr_strobe(wr_strobe),
        .ctrl_q(ctrl_q), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Every strobe must match the oldest queued write, 3 clk after the raw sck rise that completed it
    always @(negedge clk) begin
        if (!rst && wr_strobe != '0) begin
            vectors++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: wr_strobe=%b, required none", wr_strobe);
            end else begin
                mon_e = wq.pop_front();
                mon_stb = '0;
                mon_stb[mon_e.ch] = 1'b1;
                if (wr_strobe !== mon_stb) begin
                    errors++;
                    $display("FAIL strobe_bits: got %b, required %b", wr_strobe, mon_stb);
                end
                vectors++;
                if (wr_data[mon_e.ch*DW +: DW] !== mon_e.data) begin
                    errors++;
                    $display("FAIL wr_data_ch%0d: got %h, required %h", mon_e.ch, wr_data[mon_e.ch*DW +: DW], mon_e.data);
                end
                vectors++;
                if (cyc - rise_cyc !== 3) begin
                    errors++;
                    $display("FAIL strobe_latency: got %0d clk, required 3", cyc - rise_cyc);
                end
            end
        end
    end

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (4) @(negedge clk);
        m = miso;
        sck = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] v, input int n, input bit chk, input logic [DW-1:0] ev);
        logic m, e;
        if (chk) for (int i = n - 1; i >= 0; i--) mq.push_back(ev[i]);
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(v[i], m);
            if (chk) begin
                e = mq.pop_front();
                vectors++;
                if (m !== e) begin
                    errors++;
                    $display("FAIL miso_bit%0d: got %b, required %b", i, m, e);
                end
            end
        end
    endtask

    task automatic write_word(input int ch, input logic [DW-1:0] d, input bit commit);
        if (commit) begin
            wq.push_back('{ch, d});
            model[ch] = d;
        end
        send(d, DW, 0, '0);
    endtask

    task automatic frame_start();
        ncs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < N_CH; k++) model[k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if (wr_data !== '0)   begin errors++; $display("FAIL reset_wr_data: got %h, required 0", wr_data); end
        vectors++; if (wr_strobe !== '0) begin errors++; $display("FAIL reset_strobe: got %b, required 0", wr_strobe); end
        vectors++; if (ctrl_q !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h, required 00", ctrl_q); end
        vectors++; if (miso !== 1'b0)    begin errors++; $display("FAIL reset_miso: got %b, required 0", miso); end
        vectors++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_read();
        rd_data[2*DW +: DW] = 32'h01234567;
        frame_start();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b, required 1", busy); end
        send(32'h02, 8, 1, 32'hA5);
        send('0, DW, 1, 32'h01234567);
        frame_end();
        vectors++; if (ctrl_q !== 8'h02) begin errors++; $display("FAIL read_ctrl: got %h, required 02", ctrl_q); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle: got %b, required 0", busy); end
    endtask

    task automatic test_write_ainc();
        frame_start();
        send(32'hC3, 8, 1, 32'hA5);
        write_word(3, 32'hDEADBEEF, 1);
        write_word(0, 32'h11223344, 1);
        frame_end();
        vectors++; if (wq.size() != 0) begin errors++; $display("FAIL ainc_pending: got %0d writes left, required 0", wq.size()); end
        vectors++; if (wr_data[3*DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL ainc_ch3: got %h, required deadbeef", wr_data[3*DW +: DW]); end
        vectors++; if (wr_data[0 +: DW] !== 32'h11223344) begin errors++; $display("FAIL ainc_ch0: got %h, required 11223344", wr_data[0 +: DW]); end
        vectors++; if (ctrl_q !== 8'hC3) begin errors++; $display("FAIL ainc_ctrl: got %h, required c3", ctrl_q); end
    endtask

    task automatic test_abort();
        frame_start();
        send(32'h81, 8, 1, 32'hA5);
        send(32'hFFFFF, 20, 0, '0);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b, required 1", busy); end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b, required 0", busy); end
        vectors++; if (wr_data[1*DW +: DW] !== model[1]) begin errors++; $display("FAIL abort_ch1: got %h, required %h", wr_data[1*DW +: DW], model[1]); end
        vectors++; if (ctrl_q !== 8'h81) begin errors++; $display("FAIL abort_ctrl: got %h, required 81", ctrl_q); end
        repeat (5) @(negedge clk);
        frame_start();
        send(32'h7, 4, 1, 32'hA);
        frame_end();
        vectors++; if (ctrl_q !== 8'h81) begin errors++; $display("FAIL partial_ctrl: got %h, required 81", ctrl_q); end
        frame_start();
        send(32'h81, 8, 1, 32'hA5);
        write_word(1, 32'hCAFEF00D, 1);
        frame_end();
        vectors++; if (wq.size() != 0) begin errors++; $display("FAIL abort_pending: got %0d writes left, required 0", wq.size()); end
        vectors++; if (wr_data[1*DW +: DW] !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_next: got %h, required cafef00d", wr_data[1*DW +: DW]); end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < N_CH; k++) rd_data[k*DW +: DW] = 32'hF00D0000 | 32'(k);
        frame_start();
        send(32'h05, 8, 1, 32'hA5);
        send('0, DW, 1, '0);
        frame_end();
        frame_start();
        send(32'h85, 8, 1, 32'hA5);
        write_word(5, 32'h5A5A5A5A, 0);
        frame_end();
        vectors++; if (ctrl_q !== 8'h85) begin errors++; $display("FAIL oor_ctrl: got %h, required 85", ctrl_q); end
        for (int k = 0; k < N_CH; k++) begin
            vectors++;
            if (wr_data[k*DW +: DW] !== model[k]) begin errors++; $display("FAIL oor_ch%0d: got %h, required %h", k, wr_data[k*DW +: DW], model[k]); end
        end
    endtask

    task automatic test_read_repeat();
        rd_data[1*DW +: DW] = 32'hAAAA5555;
        frame_start();
        send(32'h01, 8, 1, 32'hA5);
        send('0, 16, 1, 32'hAAAA);
        rd_data[1*DW +: DW] = 32'h0F0F1234;
        send('0, 16, 1, 32'h5555);
        send('0, DW, 1, 32'h0F0F1234);
        frame_end();
        vectors++; if (ctrl_q !== 8'h01) begin errors++; $display("FAIL repeat_ctrl: got %h, required 01", ctrl_q); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d;
        d = 32'h13579BDF;
        frame_start();
        send(32'h82, 8, 1, 32'hA5);
        wq.push_back('{2, d});
        model[2] = d;
        send(d >> 1, DW - 1, 0, '0);
        mosi = d[0];
        repeat (4) @(negedge clk);
        sck = 1'b1;
        ncs = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(negedge clk);
        sck = 1'b0;
        repeat (6) @(negedge clk);
        vectors++; if (wq.size() != 0) begin errors++; $display("FAIL simul_pending: got %0d writes left, required 0", wq.size()); end
        vectors++; if (wr_data[2*DW +: DW] !== d) begin errors++; $display("FAIL simul_ch2: got %h, required %h", wr_data[2*DW +: DW], d); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        frame_start();
        send(32'h80, 8, 1, 32'hA5);
        send(32'h0000FFFF, 16, 0, '0);
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < N_CH; k++) model[k] = '0;
        vectors++; if (wr_data !== '0)   begin errors++; $display("FAIL midrst_wr_data: got %h, required 0", wr_data); end
        vectors++; if (ctrl_q !== 8'h00) begin errors++; $display("FAIL midrst_ctrl: got %h, required 00", ctrl_q); end
        vectors++; if (miso !== 1'b0)    begin errors++; $display("FAIL midrst_miso: got %b, required 0", miso); end
        vectors++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        ncs = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        frame_start();
        send(32'h80, 8, 1, 32'hA5);
        write_word(0, 32'h0BADF00D, 1);
        frame_end();
        vectors++; if (wq.size() != 0) begin errors++; $display("FAIL midrst_pending: got %0d writes left, required 0", wq.size()); end
        vectors++; if (wr_data[0 +: DW] !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_next: got %h, required 0badf00d", wr_data[0 +: DW]); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_ainc();
        test_abort();
        test_out_of_range();
        test_read_repeat();
        test_simultaneous();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
